// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU definitions: function codes understood by the 32-bit ALU and the
// state encoding of the sequential multiply controller.
package alu_mul_seq_pkg;

  // ALU function codes
  localparam logic [5:0] ALU_OP_SLL  = 6'h04;
  localparam logic [5:0] ALU_OP_SRL  = 6'h06;
  localparam logic [5:0] ALU_OP_SRA  = 6'h07;
  localparam logic [5:0] ALU_OP_MUL  = 6'h0e;
  localparam logic [5:0] ALU_OP_ADD  = 6'h20;
  localparam logic [5:0] ALU_OP_ADDI = 6'h21;
  localparam logic [5:0] ALU_OP_SUB  = 6'h22;

  // Number of shift-and-add iterations for a 32-bit multiplier
  localparam logic [5:0] MUL_ITERS = 6'd32;

  // Multiply controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_ADD,
    ST_SHL,
    ST_DONE
  } mul_state_t;

  // True for the shift function codes
  function automatic logic is_shift_op(input logic [5:0] op);
    return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential multiply controller. Implements MUL by time-sharing the external
// ALU: each partial-product accumulation is issued as ADD and each multiplicand
// shift as SLL by one. Returns the low 32 bits of op_a*op_b, which are the same
// for signed and unsigned operands.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter bit         EARLY_EXIT = 1'b1,
  parameter logic [5:0] OP_ADD     = ALU_OP_ADD,
  parameter logic [5:0] OP_SLL     = ALU_OP_SLL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_opcode,
  input  logic [31:0] alu_out
);

  mul_state_t  state, state_nxt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic        run_end;

  // The loop ends after all iterations, or early once no multiplier bits remain
  assign run_end = (cnt == MUL_ITERS) || (EARLY_EXIT && (mplier == 32'd0));

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and ALU request/operand drive
  always_comb begin
    state_nxt  = state;
    alu_req    = 1'b0;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_opcode = OP_ADD;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (run_end)        state_nxt = ST_DONE;
        else if (mplier[0]) state_nxt = ST_ADD;
        else                state_nxt = ST_SHL;
      end
      ST_ADD: begin
        alu_req    = 1'b1;
        alu_opcode = OP_ADD;
        alu_a      = acc;
        alu_b      = mcand;
        if (alu_gnt) state_nxt = ST_SHL;
      end
      ST_SHL: begin
        alu_req    = 1'b1;
        alu_opcode = OP_SLL;
        alu_a      = mcand;
        alu_b      = 32'd1;
        if (alu_gnt) state_nxt = ST_RUN;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; ALU results are only consumed in granted cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      cnt     <= 6'd0;
      product <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= 32'd0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= 6'd0;
          end
        end
        ST_RUN: begin
          // Latch the result on the way into DONE so it is visible with done
          if (run_end) product <= acc;
        end
        ST_ADD: begin
          if (alu_gnt) acc <= alu_out;
        end
        ST_SHL: begin
          if (alu_gnt) begin
            mcand  <= alu_out;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU and a reference
// model computing product, latency and ALU-operation counts arithmetically.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_out;

  int total = 0;
  int bad   = 0;

  alu_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU
  always_comb begin
    alu_out = 32'd0;
    case (alu_opcode)
      6'h20:   alu_out = alu_a + alu_b;
      6'h04:   alu_out = alu_a << alu_b[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One multiply: stall = grant-low cycles on the first ADD; poke = spurious
  // starts mid-operation and in the DONE cycle.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit poke);
    logic [31:0] exp_p;
    logic [31:0] sa, sb;
    int exp_lat, exp_add, iters, k, nadd, nsll, stall_left;
    bit got;
    exp_p   = a * b;
    iters   = 0;
    for (int i = 0; i < 32; i++) if ((b >> i) != 32'd0) iters = i + 1;
    exp_add = $countones(b);
    exp_lat = 2 + 2 * iters + exp_add + stall;
    sa = 32'd0; sb = 32'd0;
    nadd = 0; nsll = 0; got = 0; stall_left = stall;

    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = b ^ 32'h5;
    k = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!got && k <= 300) begin
      if (done) begin
        got = 1;
        check({tag, "_lat"}, k, exp_lat);
        check({tag, "_prod"}, product, exp_p);
        check({tag, "_nadd"}, nadd, exp_add);
        check({tag, "_nsll"}, nsll, iters);
        start = poke;
      end else begin
        start   = poke && (k == 3);
        alu_gnt = 1'b1;
        if (alu_req && alu_opcode == 6'h20 && stall_left > 0) begin
          if (stall_left == stall) begin
            sa = alu_a; sb = alu_b;
          end else begin
            check({tag, "_stall_req"}, {31'd0, alu_req}, 32'd1);
            check({tag, "_stall_op"}, {26'd0, alu_opcode}, 32'h20);
            check({tag, "_stall_a"}, alu_a, sa);
            check({tag, "_stall_b"}, alu_b, sb);
          end
          alu_gnt = 1'b0;
          stall_left--;
        end
        if (alu_req && alu_gnt) begin
          if (alu_opcode == 6'h20) nadd++;
          else if (alu_opcode == 6'h04) nsll++;
        end
        @(negedge clk);
        k++;
      end
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0; alu_gnt = 1'b1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_held"}, product, exp_p);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int guard;
    rst_n = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0; alu_gnt = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_prod", product, 32'd0);
    check("rst_req",  {31'd0, alu_req}, 32'd0);
    check("rst_a",    alu_a, 32'd0);
    check("rst_b",    alu_b, 32'd0);
    check("rst_op",   {26'd0, alu_opcode}, 32'h20);
    rst_n = 1'b1;
    @(negedge clk);

    run_mul("zero_b",  32'd5, 32'd0, 0, 0);
    run_mul("m7x3",    32'd7, 32'd3, 0, 0);
    run_mul("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_mul("neg3x6",  32'hFFFFFFFD, 32'd6, 0, 0);
    run_mul("zero_a",  32'd0, 32'h8000_0001, 0, 0);
    run_mul("stall4",  32'd7, 32'd3, 4, 0);
    run_mul("poke",    32'd7, 32'd3, 0, 1);

    // Asynchronous reset during the first SHL of 7*3
    @(negedge clk);
    start = 1'b1; op_a = 32'd7; op_b = 32'd3; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(alu_req && alu_opcode == 6'h04) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reach_shl", {31'd0, alu_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_prod", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_nodone", {31'd0, done}, 32'd0);
    run_mul("m6x7", 32'd6, 32'd7, 0, 0);

    // Random operands; multiplier width varied to exercise early exit
    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(31, 0);
      run_mul("rand", ra, rb, (n % 3 == 0) ? $urandom_range(3, 1) : 0, n[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
